fetch_sequencer: RTL and testbench

Controls instruction fetch for the MIPS core. It issues a req/ack handshake to instruction memory at the current PC and holds the returned instruction until the core consumes it. It grants the PC register a one-cycle update enable per consumed instruction, and drops stale fetches on a flush. It sits between the PC register / next-PC mux and the instruction memory port, turning the PC path from free-running into stall-aware.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_watchdog.sv | 45 ++++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 tb/tb_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   - fetch_state_e : FSM state encoding (IDLE, REQ, HOLD, ERR)
//   - FETCH_ADDR_W  : default PC / fetch address width
//   - FETCH_DATA_W  : default instruction width
//   - FETCH_TIMEOUT_CYCLES : default watchdog limit (only used when the
//                            FETCH_TIMEOUT_EN macro is defined)
//   - FETCH_WDOG_W  : width of the watchdog cycle counter
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int FETCH_ADDR_W         = 32;
  localparam int FETCH_DATA_W         = 32;
  localparam int FETCH_TIMEOUT_CYCLES = 64;
  localparam int FETCH_WDOG_W         = 16;

  // ERR is only reachable when the watchdog is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// -----------------------------------------------------------------------------
// fetch_watchdog
// Counts request cycles that go by without a memory response and flags when
// the limit is reached. Only instantiated by fetch_sequencer when
// FETCH_TIMEOUT_EN is defined.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   i_clear   in   restart the count (not in REQ, or flush while in REQ)
//   i_tick    in   one REQ cycle elapsed without an ack
//   o_expired out  this tick is the TIMEOUT_CYCLES-th consecutive one
// -----------------------------------------------------------------------------
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  // Count holds the number of ack-less REQ cycles already seen, so the
  // current tick is the last one when the count equals TIMEOUT_CYCLES-1.
  localparam logic [FETCH_WDOG_W-1:0] LAST_COUNT = FETCH_WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [FETCH_WDOG_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      // Never wraps: the FSM leaves REQ for ERR when LAST_COUNT is hit.
      r_cnt <= r_cnt + FETCH_WDOG_W'(1);
    end
  end

  assign o_expired = i_tick && !i_clear && (r_cnt == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Stall-aware instruction fetch control for the MIPS core. Issues a req/ack
// fetch at the current PC, holds the returned instruction until the core
// consumes it, and grants the PC register one load enable per consumed
// instruction. A flush discards any outstanding or held fetch.
//
// Optional feature: define FETCH_TIMEOUT_EN to add a request watchdog
// (fetch_watchdog) and the sticky ERR state / fetch_err flag. Without it,
// fetch_err is tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   pc           in   current PC register value
//   pc_en        out  PC register load enable (consuming cycle only)
//   imem_req     out  fetch request to instruction memory
//   imem_addr    out  fetch address (pc while requesting, else 0)
//   imem_ack     in   memory response strobe, honoured only while imem_req=1
//   imem_rdata   in   instruction data, valid with imem_ack
//   instr_valid  out  instr holds a fetched instruction
//   instr        out  registered instruction
//   core_ready   in   core consumes instr this cycle when instr_valid=1
//   flush        in   discard outstanding / held instruction
//   instr_count  out  consumed instructions since reset (wraps)
//   fetch_err    out  sticky watchdog error
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W         = FETCH_ADDR_W,
  parameter int DATA_W         = FETCH_DATA_W,
  parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  input  logic              core_ready,
  input  logic              flush,
  output logic [31:0]       instr_count,
  output logic              fetch_err
);

  // Reject an out-of-range watchdog limit at elaboration.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("fetch_sequencer: TIMEOUT_CYCLES must be within 2..65535");
  end

  fetch_state_e      r_state;
  logic [DATA_W-1:0] r_instr;
  logic [31:0]       r_count;

  logic w_in_req;
  logic w_in_hold;
  logic w_consume;

  assign w_in_req  = (r_state == REQ);
  assign w_in_hold = (r_state == HOLD);
  // Flush outranks core_ready: the redirect path owns the PC on a flush.
  assign w_consume = w_in_hold && core_ready && !flush;

`ifdef FETCH_TIMEOUT_EN
  logic w_wdog_expired;

  // Clearing whenever we are outside REQ is equivalent to clearing on entry.
  fetch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (!w_in_req || flush),
    .i_tick    (w_in_req && !imem_ack),
    .o_expired (w_wdog_expired)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        // One settle cycle for the PC register after reset; flush ignored.
        IDLE: r_state <= REQ;

        REQ: begin
          if (flush) begin
            // Any same-cycle ack belongs to the stale address; drop it.
            r_state <= REQ;
          end else if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (w_wdog_expired) begin
            r_state <= ERR;
          end
`endif
        end

        HOLD: begin
          if (flush) begin
            r_state <= REQ;
          end else if (core_ready) begin
            r_count <= r_count + 32'd1;
            r_state <= REQ;
          end
        end

        // Terminal until reset.
        ERR: r_state <= ERR;

        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req    = w_in_req;
  assign imem_addr   = w_in_req ? pc : '0;
  assign instr_valid = w_in_hold;
  assign instr       = r_instr;
  assign pc_en       = w_consume;
  assign instr_count = r_count;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = (r_state == ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed vectors, scoreboard of consumed
// instructions checked by a separate monitor on every pc_en pulse.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        core_ready;
  logic        flush;
  logic [31:0] instr_count;
  logic        fetch_err;

  // PC register model with redirect port.
  logic        redir;
  logic [31:0] redir_pc;

  int total = 0;
  int bad   = 0;
  int consumed = 0;
  logic [31:0] count_model = 32'd0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] count_before;
  } exp_t;
  exp_t exp_q[$];

  fetch_sequencer #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_en       (pc_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .core_ready  (core_ready),
    .flush       (flush),
    .instr_count (instr_count),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n)      pc <= 32'd0;
    else if (redir)  pc <= redir_pc;
    else if (pc_en)  pc <= pc + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] data);
    exp_t e;
    e.instr        = data;
    e.count_before = count_model;
    exp_q.push_back(e);
    count_model = count_model + 32'd1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},   32'(imem_req),    32'd0);
    chk({tag, "_addr"},  imem_addr,        32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr,            32'd0);
    chk({tag, "_pc_en"}, 32'(pc_en),       32'd0);
    chk({tag, "_count"}, instr_count,      32'd0);
    chk({tag, "_err"},   32'(fetch_err),   32'd0);
  endtask

  // Monitor: every consume must match the oldest expected instruction.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && pc_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_consume: got instr 0x%08h expected no consume", instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("consume_instr", instr, e.instr);
        chk("consume_count", instr_count, e.count_before);
        consumed++;
        $display("consume %0d: instr=0x%08h count=%0d (exp 0x%08h/%0d)",
                 consumed, instr, instr_count, e.instr, e.count_before);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; core_ready = 1'b0;
    flush = 1'b0; redir = 1'b0; redir_pc = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); check_reset("reset");

    // Immediate ack after reset, pc=0.
    next_cycle(); rst_n = 1'b1;                       // cycle 0: IDLE
    @(negedge clk); chk("c0_idle_req", 32'(imem_req), 32'd0);
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'h20080005; core_ready = 1'b1;
    push_exp(32'h20080005);
    @(negedge clk);                                    // cycle 1: REQ
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    chk("c1_valid", 32'(instr_valid), 32'd0);
    next_cycle(); imem_ack = 1'b0;
    @(negedge clk);                                    // cycle 2: HOLD
    chk("c2_valid", 32'(instr_valid), 32'd1);
    chk("c2_instr", instr, 32'h20080005);
    chk("c2_pc_en", 32'(pc_en), 32'd1);
    next_cycle(); core_ready = 1'b0;
    @(negedge clk);
    chk("c3_count", instr_count, 32'd1);
    chk("c3_addr", imem_addr, 32'h4);

    // Flush in REQ with redirect to 0x40, no ack.
    next_cycle(); flush = 1'b1; redir = 1'b1; redir_pc = 32'h40;
    @(negedge clk);
    chk("flreq_pc_en", 32'(pc_en), 32'd0);
    chk("flreq_req", 32'(imem_req), 32'd1);

    // Ack delayed 5 cycles at pc=0x40.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      flush = 1'b0; redir = 1'b0;
      if (i == 5) begin imem_ack = 1'b1; imem_rdata = 32'h8C090040; end
      @(negedge clk);
      chk("dly_req", 32'(imem_req), 32'd1);
      chk("dly_addr", imem_addr, 32'h40);
      chk("dly_valid", 32'(instr_valid), 32'd0);
    end
    push_exp(32'h8C090040);
    next_cycle(); imem_ack = 1'b0;

    // core_ready low for 3 HOLD cycles, consume on the 4th.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'h8C090040);
      chk("stall_pc_en", 32'(pc_en), 32'd0);
      chk("stall_count", instr_count, 32'd1);
      next_cycle();
    end
    core_ready = 1'b1;
    @(negedge clk); chk("stall_consume", 32'(pc_en), 32'd1);
    next_cycle(); core_ready = 1'b0;
    @(negedge clk);
    chk("post_stall_count", instr_count, 32'd2);
    chk("post_stall_addr", imem_addr, 32'h44);
    chk("post_stall_valid", 32'(instr_valid), 32'd0);

    // Flush coincident with ack in REQ: data dropped.
    next_cycle(); imem_ack = 1'b1; flush = 1'b1; imem_rdata = 32'hDEADBEEF;
    redir = 1'b1; redir_pc = 32'h100;
    @(negedge clk); chk("flack_pc_en", 32'(pc_en), 32'd0);
    next_cycle(); imem_ack = 1'b0; flush = 1'b0; redir = 1'b0;
    @(negedge clk);
    chk("flack_req", 32'(imem_req), 32'd1);
    chk("flack_valid", 32'(instr_valid), 32'd0);
    chk("flack_addr", imem_addr, 32'h100);
    chk("flack_instr", instr, 32'h8C090040);

    // Fetch then flush in HOLD with core_ready=1: no consume.
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'h24020001;
    @(negedge clk); chk("flhold_req_addr", imem_addr, 32'h100);
    next_cycle(); imem_ack = 1'b0; flush = 1'b1; core_ready = 1'b1;
    redir = 1'b1; redir_pc = 32'h200;
    @(negedge clk);
    chk("flhold_valid", 32'(instr_valid), 32'd1);
    chk("flhold_instr", instr, 32'h24020001);
    chk("flhold_pc_en", 32'(pc_en), 32'd0);
    next_cycle(); flush = 1'b0; core_ready = 1'b0; redir = 1'b0;
    @(negedge clk);
    chk("flhold_valid_drop", 32'(instr_valid), 32'd0);
    chk("flhold_req", 32'(imem_req), 32'd1);
    chk("flhold_addr", imem_addr, 32'h200);
    chk("flhold_count", instr_count, 32'd2);

    // Back-to-back fetches at full throughput.
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'h00851020; core_ready = 1'b1;
    push_exp(32'h00851020);
    @(negedge clk); chk("tp_addr0", imem_addr, 32'h200);
    next_cycle(); imem_ack = 1'b0;
    @(negedge clk); chk("tp_pc_en0", 32'(pc_en), 32'd1);
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'h03E00008;
    push_exp(32'h03E00008);
    @(negedge clk);
    chk("tp_req1", 32'(imem_req), 32'd1);
    chk("tp_addr1", imem_addr, 32'h204);
    chk("tp_count1", instr_count, 32'd3);
    next_cycle(); imem_ack = 1'b0;
    @(negedge clk); chk("tp_instr1", instr, 32'h03E00008);
    next_cycle(); core_ready = 1'b0;
    @(negedge clk);
    chk("tp_count2", instr_count, 32'd4);
    chk("tp_addr2", imem_addr, 32'h208);

    // Reset while holding an instruction; late ack after reset ignored.
    next_cycle(); imem_ack = 1'b1; imem_rdata = 32'h11111111;
    next_cycle(); imem_ack = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rsthold_valid", 32'(instr_valid), 32'd1);
    chk("rsthold_instr", instr, 32'h11111111);
    next_cycle(); rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h22222222;
    count_model = 32'd0;
    @(negedge clk); check_reset("rsthold");
    next_cycle(); imem_ack = 1'b0;
    @(negedge clk);
    chk("late_req", 32'(imem_req), 32'd1);
    chk("late_valid", 32'(instr_valid), 32'd0);
    chk("late_instr", instr, 32'd0);
    chk("late_addr", imem_addr, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    // No ack ever: ERR after 8 REQ cycles, sticky until reset.
    for (int k = 2; k <= 8; k++) begin
      next_cycle();
      @(negedge clk);
      chk("wd_err_low", 32'(fetch_err), 32'd0);
      chk("wd_req_high", 32'(imem_req), 32'd1);
    end
    next_cycle(); imem_ack = 1'b1;
    @(negedge clk);
    chk("wd_err", 32'(fetch_err), 32'd1);
    chk("wd_req", 32'(imem_req), 32'd0);
    chk("wd_valid", 32'(instr_valid), 32'd0);
    repeat (3) next_cycle();
    imem_ack = 1'b0;
    @(negedge clk); chk("wd_sticky", 32'(fetch_err), 32'd1);
    next_cycle(); rst_n = 1'b0;
    next_cycle(); rst_n = 1'b1;
    @(negedge clk); check_reset("wd_rst");
`else
    repeat (10) next_cycle();
    @(negedge clk);
    chk("noto_err", 32'(fetch_err), 32'd0);
    chk("noto_req", 32'(imem_req), 32'd1);
`endif

    next_cycle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("consumed_total", 32'(consumed), 32'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
